// File: rtl/du_host_driver.sv
// Host-side driver for a debug unit reached over a UART byte link: it sends
// load/run/step commands, streams program bytes, and collects the 260-byte dump.
module du_host_driver #(
    parameter int                BYTE       = 8,
    parameter int                DWORD      = 32,
    parameter int                DUMP_BYTES = 260,
    parameter int                TIMEOUT    = 1000000,
    parameter logic [BYTE-1:0]   CMD_LOAD   = 8'h01,
    parameter logic [BYTE-1:0]   CMD_RUN    = 8'h02,
    parameter logic [BYTE-1:0]   CMD_STEP   = 8'h03
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    input  logic [BYTE-1:0]  i_prog_len,
    input  logic [BYTE-1:0]  i_prog_data,
    output logic [BYTE-1:0]  o_prog_addr,
    output logic [BYTE-1:0]  o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_done,
    input  logic [BYTE-1:0]  i_rx_data,
    input  logic             i_rx_done,
    output logic             o_cmd_ready,
    output logic             o_busy,
    output logic             o_dump_valid,
    output logic [8:0]       o_dump_index,
    output logic [BYTE-1:0]  o_dump_data,
    output logic [DWORD-1:0] o_pc,
    output logic             o_done,
    output logic             o_error
);
    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   T_ONE  = 1;
    localparam logic [8:0]      D_LAST = 9'(DUMP_BYTES - 1);
    localparam logic [BYTE-1:0] B_ONE  = 1;

    typedef enum logic [3:0] {
        IDLE, SEND_CMD, WAIT_CMD, SEND_LEN, WAIT_LEN,
        FETCH, SEND_PROG, WAIT_PROG, RECV_DUMP
    } state_t;

    state_t          r_state, w_next;
    logic            w_start, w_done, w_timeout;
    logic [BYTE-1:0] w_cmd_byte;
    logic [1:0]      r_cmd;
    logic [BYTE-1:0] r_len;
    logic [BYTE-1:0] r_tx_data;
    logic [BYTE-1:0] r_prog_addr;
    logic [8:0]      r_count;
    logic [TW-1:0]   r_timer;
    logic            r_dump_valid;
    logic [8:0]      r_dump_index;
    logic [BYTE-1:0] r_dump_data;
    logic [DWORD-1:0] r_pc;
    logic            r_done;
    logic            r_error;

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:      if (i_cmd_valid && i_cmd != 2'd0) begin
                           w_start = 1'b1;
                           w_next  = SEND_CMD;
                       end
            SEND_CMD:  w_next = WAIT_CMD;
            WAIT_CMD:  if (i_tx_done) w_next = (r_cmd == 2'd1) ? SEND_LEN : RECV_DUMP;
            SEND_LEN:  w_next = WAIT_LEN;
            WAIT_LEN:  if (i_tx_done) begin
                           if (r_len == '0) begin
                               w_next = IDLE;
                               w_done = 1'b1;
                           end else begin
                               w_next = FETCH;
                           end
                       end
            FETCH:     w_next = SEND_PROG;
            SEND_PROG: w_next = WAIT_PROG;
            WAIT_PROG: if (i_tx_done) begin
                           if (r_prog_addr == r_len - B_ONE) begin
                               w_next = IDLE;
                               w_done = 1'b1;
                           end else begin
                               w_next = FETCH;
                           end
                       end
            RECV_DUMP: if (i_rx_done) begin
                           if (r_count == D_LAST) begin
                               w_next = IDLE;
                               w_done = 1'b1;
                           end
                       end else if (r_timer == T_LAST) begin
                           w_next    = IDLE;
                           w_timeout = 1'b1;
                       end
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        case (i_cmd)
            2'd1:    w_cmd_byte = CMD_LOAD;
            2'd2:    w_cmd_byte = CMD_RUN;
            default: w_cmd_byte = CMD_STEP;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cmd        <= '0;
            r_len        <= '0;
            r_tx_data    <= '0;
            r_prog_addr  <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_dump_valid <= 1'b0;
            r_dump_index <= '0;
            r_dump_data  <= '0;
            r_pc         <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done       <= w_done;
            r_dump_valid <= 1'b0;
            if (w_timeout) r_error <= 1'b1;
            case (r_state)
                IDLE: if (w_start) begin
                    r_cmd       <= i_cmd;
                    r_len       <= i_prog_len;
                    r_tx_data   <= w_cmd_byte;
                    r_prog_addr <= '0;
                    r_error     <= 1'b0;
                end
                WAIT_CMD: if (i_tx_done) begin
                    r_tx_data <= r_len;
                    r_count   <= '0;
                    r_timer   <= '0;
                end
                SEND_PROG: r_tx_data <= i_prog_data;
                WAIT_PROG: if (i_tx_done && w_next == FETCH) r_prog_addr <= r_prog_addr + B_ONE;
                RECV_DUMP: if (i_rx_done) begin
                    r_dump_valid <= 1'b1;
                    r_dump_index <= r_count;
                    r_dump_data  <= i_rx_data;
                    r_count      <= r_count + 9'd1;
                    r_timer      <= '0;
                    // The first four dump bytes carry the PC, most significant first.
                    if (r_count < 9'd4) r_pc <= {r_pc[DWORD-BYTE-1:0], i_rx_data};
                end else begin
                    r_timer <= r_timer + T_ONE;
                end
                default: ;
            endcase
        end
    end

    // The ROM answers one cycle after the address moves, so the program byte
    // is forwarded straight through while SEND_PROG is active.
    assign o_tx_data    = (r_state == SEND_PROG) ? i_prog_data : r_tx_data;
    assign o_tx_start   = (r_state == SEND_CMD) || (r_state == SEND_LEN) || (r_state == SEND_PROG);
    assign o_cmd_ready  = (r_state == IDLE);
    assign o_busy       = (r_state != IDLE);
    assign o_prog_addr  = r_prog_addr;
    assign o_dump_valid = r_dump_valid;
    assign o_dump_index = r_dump_index;
    assign o_dump_data  = r_dump_data;
    assign o_pc         = r_pc;
    assign o_done       = r_done;
    assign o_error      = r_error;
endmodule

// File: tb/tb_du_host_driver.sv
// Directed-plus-random bench for du_host_driver with a UART/ROM responder and
// a transaction-level model of the expected byte streams.
module tb_du_host_driver;
    localparam int TMO   = 50;
    localparam int NDUMP = 260;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1, i_cmd_valid = 1'b0, i_tx_done = 1'b0, i_rx_done = 1'b0;
    logic [1:0]  i_cmd = 2'd0;
    logic [7:0]  i_prog_len = 8'd0, i_prog_data = 8'd0, i_rx_data = 8'd0;
    logic [7:0]  o_prog_addr, o_tx_data, o_dump_data;
    logic        o_tx_start, o_cmd_ready, o_busy, o_dump_valid, o_done, o_error;
    logic [8:0]  o_dump_index;
    logic [31:0] o_pc;

    always #5 clk = ~clk;

    du_host_driver #(.TIMEOUT(TMO)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
        .i_prog_len(i_prog_len), .i_prog_data(i_prog_data), .o_prog_addr(o_prog_addr),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .o_cmd_ready(o_cmd_ready),
        .o_busy(o_busy), .o_dump_valid(o_dump_valid), .o_dump_index(o_dump_index),
        .o_dump_data(o_dump_data), .o_pc(o_pc), .o_done(o_done), .o_error(o_error)
    );

    // Synchronous program ROM: data follows the address by one clock.
    logic [7:0] rom [256];
    always @(posedge clk) i_prog_data <= rom[o_prog_addr];

    logic [7:0] tx_log [$];
    logic [8:0] dump_idx [$];
    logic [7:0] dump_dat [$];
    int tx_cnt = 0, tx_delay = 10, tx_overlap = 0, done_cnt = 0;
    int n_assert = 0, n_fail = 0;

    // UART transmitter stand-in: i_tx_done fires tx_delay cycles after each start.
    always @(negedge clk) begin
        i_tx_done = 1'b0;
        if (o_tx_start) begin
            tx_log.push_back(o_tx_data);
            if (tx_cnt != 0) tx_overlap++;
            tx_cnt = tx_delay;
        end else if (tx_cnt != 0) begin
            tx_cnt--;
            if (tx_cnt == 0) i_tx_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (o_dump_valid) begin
            dump_idx.push_back(o_dump_index);
            dump_dat.push_back(o_dump_data);
        end
        if (o_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        tx_log.delete(); dump_idx.delete(); dump_dat.delete(); done_cnt = 0;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [7:0] len);
        for (int i = 0; i < 100 && !o_cmd_ready; i++) @(negedge clk);
        i_cmd = cmd; i_prog_len = len; i_cmd_valid = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        for (int i = 0; i < limit && o_busy; i++) @(negedge clk);
        check(tag, {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input string tag);
        for (int i = 0; i < 200 && tx_log.size() < n; i++) @(negedge clk);
        check(tag, (tx_log.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap);
        i_rx_data = b; i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'd0, o_cmd_ready}, 32'd1);
        check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
        check({tag, "_start"}, {31'd0, o_tx_start}, 32'd0);
        check({tag, "_dv"},    {31'd0, o_dump_valid}, 32'd0);
        check({tag, "_done"},  {31'd0, o_done}, 32'd0);
        check({tag, "_err"},   {31'd0, o_error}, 32'd0);
        check({tag, "_addr"},  {24'd0, o_prog_addr}, 32'd0);
        check({tag, "_txd"},   {24'd0, o_tx_data}, 32'd0);
        check({tag, "_didx"},  {23'd0, o_dump_index}, 32'd0);
        check({tag, "_ddat"},  {24'd0, o_dump_data}, 32'd0);
        check({tag, "_pc"},    o_pc, 32'd0);
    endtask

    // Model: a load emits {01, len, rom[0..len-1]}, ends with one o_done and
    // leaves the address on the last byte fetched.
    task automatic run_load(input int len, input string tag);
        logic [7:0] exp_tx [$];
        clear_logs();
        exp_tx.push_back(8'h01);
        exp_tx.push_back(8'(len));
        for (int i = 0; i < len; i++) exp_tx.push_back(rom[i]);
        issue(2'd1, 8'(len));
        wait_idle(40 * (len + 2), {tag, "_idle"});
        check({tag, "_ntx"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++)
            if (i < tx_log.size()) check($sformatf("%s_tx%0d", tag, i), {24'd0, tx_log[i]}, {24'd0, exp_tx[i]});
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_addr"}, {24'd0, o_prog_addr}, (len == 0) ? 32'd0 : 32'(len - 1));
    endtask

    // Model: a run/step emits one command byte, then every received byte is
    // presented in order with its position; the PC is bytes 0..3 big-endian.
    task automatic run_dump(input logic [1:0] cmd, input logic [7:0] first4 [4], input string tag);
        logic [7:0]  rxb [NDUMP];
        logic [31:0] exp_pc;
        int          bad_idx, bad_dat;
        clear_logs();
        for (int i = 0; i < NDUMP; i++) rxb[i] = (i < 4) ? first4[i] : 8'($urandom);
        exp_pc = 32'(rxb[0]) * 32'h0100_0000 + 32'(rxb[1]) * 32'h0001_0000 + 32'(rxb[2]) * 32'h100 + 32'(rxb[3]);
        issue(cmd, 8'd0);
        wait_tx(1, {tag, "_cmdtx"});
        repeat (tx_delay + 2) @(negedge clk);
        for (int i = 0; i < NDUMP; i++) begin
            send_rx(rxb[i], (i == 3) ? 0 : $urandom_range(0, 4));
            if (i == 3) check({tag, "_pc_b3"}, o_pc, exp_pc);
        end
        wait_idle(20, {tag, "_idle"});
        check({tag, "_ntx"}, tx_log.size(), 1);
        if (tx_log.size() > 0) check({tag, "_cmdbyte"}, {24'd0, tx_log[0]}, {30'd0, cmd});
        check({tag, "_ndump"}, dump_idx.size(), NDUMP);
        bad_idx = 0; bad_dat = 0;
        for (int i = 0; i < NDUMP && i < dump_idx.size(); i++) begin
            if (dump_idx[i] !== 9'(i)) bad_idx++;
            if (dump_dat[i] !== rxb[i]) bad_dat++;
        end
        check({tag, "_bad_idx"}, bad_idx, 0);
        check({tag, "_bad_dat"}, bad_dat, 0);
        check({tag, "_pc_end"}, o_pc, exp_pc);
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_err"}, {31'd0, o_error}, 32'd0);
    endtask

    initial begin
        logic [7:0] f4 [4];
        int n;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        i_reset = 1'b0;
        @(negedge clk);

        // Directed load of AA,BB,CC with 10-cycle UART latency.
        rom[0] = 8'hAA; rom[1] = 8'hBB; rom[2] = 8'hCC;
        tx_delay = 10;
        run_load(3, "load3");
        run_load(0, "load0");

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
            tx_delay = $urandom_range(1, 6);
            run_load($urandom_range(1, 20), $sformatf("rload%0d", k));
        end

        tx_delay = 4;
        f4[0] = 8'h00; f4[1] = 8'h00; f4[2] = 8'h00; f4[3] = 8'h2C;
        run_dump(2'd3, f4, "step");
        for (int i = 0; i < 4; i++) f4[i] = 8'($urandom);
        run_dump(2'd2, f4, "run");

        // Dump stalls after 10 bytes: error after exactly TMO idle cycles.
        clear_logs();
        issue(2'd2, 8'd0);
        wait_tx(1, "tmo_cmdtx");
        repeat (tx_delay + 2) @(negedge clk);
        for (int i = 0; i < 10; i++) send_rx(8'($urandom), (i == 9) ? 0 : $urandom_range(0, 4));
        n = 0;
        while (!o_error && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_busy", {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("tmo_done", done_cnt, 0);
        check("tmo_ndump", dump_idx.size(), 10);
        issue(2'd1, 8'd0);
        check("tmo_errclr", {31'd0, o_error}, 32'd0);
        wait_idle(100, "tmo_next_idle");

        // Reset between AA and BB of a load.
        rom[0] = 8'hAA; rom[1] = 8'hBB; rom[2] = 8'hCC;
        tx_delay = 10;
        clear_logs();
        issue(2'd1, 8'd3);
        wait_tx(3, "rstmid_aa");
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check_reset_vals("rstmid");
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rstmid_ntx", tx_log.size(), 3);
        check("rstmid_done", done_cnt, 0);
        check("rstmid_idle", {31'd0, o_cmd_ready}, 32'd1);

        // Stray rx in IDLE and a command offered while busy are both dropped.
        clear_logs();
        send_rx(8'h55, 3);
        check("stray_rx", dump_idx.size(), 0);
        issue(2'd2, 8'd0);
        wait_tx(1, "busy_cmdtx");
        @(negedge clk);
        check("busy_ready", {31'd0, o_cmd_ready}, 32'd0);
        i_cmd = 2'd1; i_prog_len = 8'd5; i_cmd_valid = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        wait_idle(200, "busy_idle");
        repeat (30) @(negedge clk);
        check("busy_ntx", tx_log.size(), 1);
        if (tx_log.size() > 0) check("busy_txbyte", {24'd0, tx_log[0]}, 32'h02);
        check("busy_ndump", dump_idx.size(), 0);
        check("busy_err", {31'd0, o_error}, 32'd1);
        check("busy_done", done_cnt, 0);

        check("tx_overlap", tx_overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
